shift_add_multi_param: RTL and testbench
========================================

// Module: shift_add_multi_param
// PURPOSE
//  Parametrised sequential shift-add multiplier; successor to the fixed 16-bit calculator multiplier.
//  Adds configurable operand width, a signed/unsigned mode, optional early termination and a busy flag.
//  Sits between the UART command parser (start pulse, operands) and the result formatter (done pulse, product).
//  Processes one multiplier bit per clock. Signed mode multiplies magnitudes, then sign-corrects the product.
// PARAMETERS
//  WIDTH      16  operand width in bits, >=2; product is 2*WIDTH bits
//  SIGNED_EN  1   1: signed_mode port honoured; 0: signed_mode ignored, always unsigned
//  EARLY_TERM 1   1: leave CALC once the remaining multiplier bits are all zero; 0: always WIDTH CALC cycles
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request pulse from parser; sampled only in IDLE
//  signed_mode  in   1        1 = two's-complement operands; sampled with start
//  src1         in   WIDTH    multiplicand; sampled with start
//  src2         in   WIDTH    multiplier; sampled with start
//  busy         out  1        1 while state != IDLE
//  multi_done   out  1        one-cycle pulse, high exactly while in DONE
//  calc_res     out  2*WIDTH  product; registered, holds until the next DONE
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, multi_done=0, calc_res=0, internal acc/mcand/mplr/cnt=0. Applies immediately, any state.
//  FSM IDLE -> CALC -> DONE -> IDLE. multi_done and busy decode from the state register (no combinational input path).
//  IDLE: start=1 at an edge latches the operands and moves to CALC. neg = signed_mode&SIGNED_EN&(src1[MSB]^src2[MSB]).
//   mcand = |src1| zero-extended to 2*WIDTH bits; mplr = |src2| (WIDTH bits); acc=0; cnt=0.
//   Magnitude is taken only in signed mode. Most-negative value: |-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned in WIDTH bits.
//  CALC, each cycle: acc += mplr[0] ? mcand : 0; mcand <<= 1; mplr >>= 1; cnt++.
//   Leave for DONE after the cycle in which cnt==WIDTH-1, or (EARLY_TERM && (mplr>>1)==0).
//   On that exit edge: calc_res <= neg ? -(acc_next) : acc_next, computed mod 2^(2*WIDTH). No overflow is possible.
//  DONE: one cycle; multi_done=1; calc_res already valid; then IDLE unconditionally.
//  Latency, from the edge that samples start: CALC lasts N cycles, then DONE lasts 1 cycle.
//   multi_done is high during cycle N+1 after that edge.
//   N = WIDTH when EARLY_TERM=0.
//   N = max(1, bit index of the highest set bit of |src2| + 1) when EARLY_TERM=1 (N=1 for src2==0).
//  start in CALC or DONE is ignored and not queued. Operand changes after sampling have no effect.
//  Minimum spacing between accepted starts is N+2 cycles: start must be seen in the IDLE cycle after DONE.
//  Reset mid-CALC/DONE: no multi_done pulse, calc_res=0, next start accepted normally.
//  calc_res changes only on the CALC->DONE edge or reset. It is stable in IDLE for the formatter.
// TESTING (WIDTH=16 unless noted)
//  1. EARLY_TERM=0, unsigned, 0xFFFF*0xFFFF -> calc_res=0xFFFE0001; multi_done high exactly 17 cycles after the start edge, one cycle wide.
//  2. Signed: -1*-1 -> 0x00000001; 0x8000*0x8000 -> 0x40000000; 0x8000*0x0001 -> 0xFFFF8000; 7*-3 -> 0xFFFFFFEB.
//  3. SIGNED_EN=0 with signed_mode=1: 0xFFFF*0x0002 -> 0x0001FFFE (unsigned result).
//  4. EARLY_TERM=1: 0x1234*0x0000 -> 0, done 2 cycles after start; 5*0x0003 -> 15, done 3 cycles after start.
//  5. start pulsed every cycle while busy, operands toggling -> only the first request is computed; busy stays 1 until DONE exits.
//  6. rst=1 asserted mid-CALC -> busy=0, calc_res=0, no multi_done; then 3*4 -> 12.
//  7. Random sweep, WIDTH in {2,8,16,32}, both modes, both EARLY_TERM values -> matches the reference model; latency matches the N formula.

Source files
------------

// File: rtl/shift_add_multi_param.sv
// Sequential shift-add multiplier: one multiplier bit per clock, optional
// signed operation (magnitudes multiplied, product sign-corrected at the end),
// optional early exit once no set multiplier bits remain.
module shift_add_multi_param #(
    parameter int WIDTH      = 16,
    parameter int SIGNED_EN  = 1,
    parameter int EARLY_TERM = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    output logic               busy,
    output logic               multi_done,
    output logic [2*WIDTH-1:0] calc_res
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_res;

    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;
    logic [2*WIDTH-1:0] w_res_final;

    // Operand magnitudes are only taken when signed operation is both enabled and requested;
    // the most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    assign w_sgn  = (SIGNED_EN != 0) && signed_mode;
    assign w_mag1 = (w_sgn && src1[WIDTH-1]) ? (WIDTH'(0) - src1) : src1;
    assign w_mag2 = (w_sgn && src2[WIDTH-1]) ? (WIDTH'(0) - src2) : src2;
    assign w_neg  = w_sgn && (src1[WIDTH-1] ^ src2[WIDTH-1]);

    // One partial product per cycle; exit on the final bit or when the remaining multiplier is empty.
    assign w_acc_next  = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_last      = (r_cnt == CW'(WIDTH - 1)) ||
                         ((EARLY_TERM != 0) && ((r_mplr >> 1) == '0));
    assign w_res_final = r_neg ? ((2*WIDTH)'(0) - w_acc_next) : w_acc_next;

    // Status flags decode straight from the state register.
    assign busy       = (r_state != S_IDLE);
    assign multi_done = (r_state == S_DONE);
    assign calc_res   = r_res;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_res   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_mag1};
                        r_mplr  <= w_mag2;
                        r_cnt   <= '0;
                        r_neg   <= w_neg;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res   <= w_res_final;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multi_param.sv
// Bench for shift_add_multi_param: eight parameter configurations driven from
// one shared stimulus, each tracked by a cycle-count timeline model and
// checked every cycle, plus hand-computed literal results and latencies.
module tb_shift_add_multi_param;

    localparam int NI = 8;

    function automatic int cfg_w(input int i);
        case (i)
            0, 1, 2, 3: return 16;
            4:          return 2;
            5:          return 8;
            default:    return 32;
        endcase
    endfunction

    function automatic int cfg_se(input int i);
        return (i == 2 || i == 3 || i == 7) ? 0 : 1;
    endfunction

    function automatic int cfg_et(input int i);
        return (i == 1 || i == 3 || i == 4 || i == 6) ? 1 : 0;
    endfunction

    // Reference product: plain integer multiply of the interpreted operands, mod 2^(2w).
    function automatic logic [63:0] f_prod(input int w, input int se, input int sm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask;
        logic [31:0] wm;
        longint      sa, sb, p;
        mask = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 2*w);
        wm   = 32'hFFFF_FFFF >> (32 - w);
        sa   = longint'(a & wm);
        sb   = longint'(b & wm);
        if (se != 0 && sm != 0) begin
            if (sa[w-1]) sa = sa - (longint'(1) << w);
            if (sb[w-1]) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return 64'(p) & mask;
    endfunction

    // Number of CALC cycles from the latency rule.
    function automatic int f_n(input int w, input int se, input int et, input int sm,
                               input logic [31:0] b);
        logic [63:0] bb;
        int          n;
        if (et == 0) return w;
        bb = 64'(b & (32'hFFFF_FFFF >> (32 - w)));
        if (se != 0 && sm != 0 && bb[w-1]) bb = (64'd1 << w) - bb;
        n = 1;
        for (int i = 0; i < w; i++) if (bb[i]) n = i + 1;
        return n;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;

    logic [NI-1:0] busy_all;
    logic [NI-1:0] done_all;
    logic [63:0]   res_all [NI];

    int total = 0;
    int bad   = 0;
    int lat   [NI];
    int ndone [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int W  = cfg_w(gi);
            localparam int SE = cfg_se(gi);
            localparam int ET = cfg_et(gi);

            logic           w_busy;
            logic           w_done;
            logic [2*W-1:0] w_res;

            shift_add_multi_param #(
                .WIDTH(W), .SIGNED_EN(SE), .EARLY_TERM(ET)
            ) u_dut (
                .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
                .src1(src1[W-1:0]), .src2(src2[W-1:0]),
                .busy(w_busy), .multi_done(w_done), .calc_res(w_res)
            );

            assign busy_all[gi] = w_busy;
            assign done_all[gi] = w_done;
            assign res_all[gi]  = 64'(w_res);

            // Timeline model: remaining CALC cycles, a done flag and the visible result.
            int          m_left = 0;
            logic        m_done = 1'b0;
            logic [63:0] m_res  = '0;
            logic [63:0] m_pend = '0;

            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_left <= 0;
                    m_done <= 1'b0;
                    m_res  <= '0;
                end else if (m_done) begin
                    m_done <= 1'b0;
                end else if (m_left > 0) begin
                    if (m_left == 1) begin
                        m_left <= 0;
                        m_done <= 1'b1;
                        m_res  <= m_pend;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end else if (start) begin
                    m_left <= f_n(W, SE, ET, int'(sm), src1);
                    m_left <= f_n(W, SE, ET, int'(sm), src2);
                    m_pend <= f_prod(W, SE, int'(sm), src1, src2);
                end
            end

            // Per-cycle comparison of all outputs against the model.
            always @(negedge clk) begin
                logic exp_busy;
                exp_busy = (m_left != 0) || m_done;
                total++;
                if (w_busy !== exp_busy || w_done !== m_done || 64'(w_res) !== m_res) begin
                    bad++;
                    $display("FAIL cycle_cmp inst=%0d t=%0t busy=%b exp=%b done=%b exp=%b res=%h exp=%h",
                             gi, $time, w_busy, exp_busy, w_done, m_done, 64'(w_res), m_res);
                end
            end
        end
    endgenerate

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Waits (bounded) until every instance is idle, recording done cycles relative to the start edge.
    task automatic wait_idle(input int first_cyc, input int last_drive);
        bit idle;
        idle = 1'b0;
        for (int cyc = first_cyc; cyc < first_cyc + 80; cyc++) begin
            @(negedge clk);
            if (cyc == last_drive) start = 1'b0;
            for (int k = 0; k < NI; k++) begin
                if (done_all[k]) begin
                    if (ndone[k] == 0) lat[k] = cyc;
                    ndone[k]++;
                end
            end
            if (busy_all == '0) begin
                idle = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(idle), 64'd1);
    endtask

    // One transaction: a single-cycle start, then wait for completion and check latencies.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic m);
        src1  = a;
        src2  = b;
        sm    = m;
        start = 1'b1;
        for (int k = 0; k < NI; k++) begin
            lat[k]   = 0;
            ndone[k] = 0;
        end
        @(posedge clk);
        wait_idle(1, 1);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("lat_inst%0d", k), 64'(lat[k]),
                  64'(f_n(cfg_w(k), cfg_se(k), cfg_et(k), int'(m), b) + 1));
            check($sformatf("ndone_inst%0d", k), 64'(ndone[k]), 64'd1);
        end
        $display("txn a=%h b=%h sm=%0d res16u=%h res16s=%h", a, b, m, res_all[0], res_all[1]);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) check($sformatf("rst_res%0d", k), res_all[k], 64'd0);
        check("rst_busy", 64'(busy_all), 64'd0);
        check("rst_done", 64'(done_all), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-width unsigned, fixed latency.
        run_txn(32'hFFFF, 32'hFFFF, 1'b0);
        check("t1_res", res_all[0], 64'hFFFE_0001);
        check("t1_lat", 64'(lat[0]), 64'd17);

        // Signed corner cases.
        run_txn(32'hFFFF, 32'hFFFF, 1'b1);
        check("t2_m1m1", res_all[1], 64'h0000_0001);
        run_txn(32'h8000, 32'h8000, 1'b1);
        check("t2_minmin", res_all[1], 64'h4000_0000);
        run_txn(32'h8000, 32'h0001, 1'b1);
        check("t2_minone", res_all[1], 64'hFFFF_8000);
        run_txn(32'h0007, 32'hFFFD, 1'b1);
        check("t2_7m3_et", res_all[1], 64'hFFFF_FFEB);
        check("t2_7m3", res_all[0], 64'hFFFF_FFEB);

        // Signed mode ignored when disabled.
        run_txn(32'hFFFF, 32'h0002, 1'b1);
        check("t3_se0", res_all[2], 64'h0001_FFFE);
        check("t3_se0_et", res_all[3], 64'h0001_FFFE);

        // Early termination latencies.
        run_txn(32'h1234, 32'h0000, 1'b0);
        check("t4_zero", res_all[1], 64'd0);
        check("t4_zero_lat", 64'(lat[1]), 64'd2);
        run_txn(32'h0005, 32'h0003, 1'b0);
        check("t4_5x3", res_all[1], 64'd15);
        check("t4_5x3_lat", 64'(lat[1]), 64'd3);

        // Start held high with toggling operands while busy.
        src1 = 32'h3; src2 = 32'h5; sm = 1'b0; start = 1'b1;
        for (int k = 0; k < NI; k++) begin
            lat[k] = 0; ndone[k] = 0;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            src1 = $urandom;
            src2 = $urandom;
            sm   = 1'($urandom_range(0, 1));
            for (int k = 0; k < NI; k++) if (done_all[k]) begin
                if (ndone[k] == 0) lat[k] = cyc;
                ndone[k]++;
            end
            if (cyc == 15) start = 1'b0;
        end
        wait_idle(16, 0);
        check("t5_res", res_all[0], 64'd15);
        check("t5_lat", 64'(lat[0]), 64'd17);
        check("t5_ndone", 64'(ndone[0]), 64'd1);
        $display("txn stress start-while-busy res16u=%h", res_all[0]);

        // Reset in the middle of a calculation.
        src1 = 32'hFFFF; src2 = 32'hFFFF; sm = 1'b0; start = 1'b1;
        ndone[0] = 0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_all[0]) ndone[0]++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (done_all[0]) ndone[0]++;
        for (int k = 0; k < NI; k++) check($sformatf("t6_res%0d", k), res_all[k], 64'd0);
        check("t6_busy", 64'(busy_all), 64'd0);
        check("t6_nodone", 64'(ndone[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("txn reset mid-calc");
        run_txn(32'h3, 32'h4, 1'b0);
        check("t6_3x4", res_all[0], 64'd12);
        check("t6_3x4_et", res_all[1], 64'd12);
        check("t6_3x4_w32", res_all[6], 64'd12);

        // Random sweep across all configurations.
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
